// File: rtl/spi_cmd_decoder_pkg.sv
// Shared definitions for the SPI command decoder: FSM states, opcode field
// positions and the number of addressable control modules.
package spi_cmd_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OPCODE  = 3'd1,
    ST_FETCH   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DATA    = 3'd4,
    ST_LOAD    = 3'd5,
    ST_HOLD    = 3'd6
  } state_t;

  localparam int OP_RW_BIT = 7;
  localparam int OP_MOD_HI = 6;
  localparam int OP_MOD_LO = 5;
  localparam int OP_IOC_HI = 4;
  localparam int OP_IOC_LO = 0;
  localparam int MOD_W     = OP_MOD_HI - OP_MOD_LO + 1;
  localparam int IOC_W     = OP_IOC_HI - OP_IOC_LO + 1;
  localparam int NUM_MODS  = 4;

  function automatic logic [NUM_MODS-1:0] mod_onehot(input logic [MOD_W-1:0] mod);
    logic [NUM_MODS-1:0] oh;
    oh      = '0;
    oh[mod] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/spi_cmd_decoder_edge_sync.sv
// Brings the asynchronous SPI pins into the system clock domain and produces
// single-cycle edge pulses for SCK and nCS.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_sys_clk,
  input  logic i_rst,
  input  logic i_sck,
  input  logic i_ncs,
  input  logic i_mosi,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_ncs_rise,
  output logic o_ncs_fall,
  output logic o_ncs_sync,
  output logic o_mosi_sync
);

  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] ncs_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sck_prev_q;
  logic                   ncs_prev_q;

  // Reset presets the chains to an idle bus so no phantom edge follows reset.
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      sck_q      <= '0;
      ncs_q      <= '1;
      sck_prev_q <= 1'b0;
      ncs_prev_q <= 1'b1;
    end else begin
      sck_q      <= {sck_q[SYNC_STAGES-2:0], i_sck};
      ncs_q      <= {ncs_q[SYNC_STAGES-2:0], i_ncs};
      sck_prev_q <= sck_q[SYNC_STAGES-1];
      ncs_prev_q <= ncs_q[SYNC_STAGES-1];
    end
  end

  // MOSI uses the same depth so it stays aligned with the SCK edge pulses.
  always_ff @(posedge i_sys_clk) begin
    mosi_q <= {mosi_q[SYNC_STAGES-2:0], i_mosi};
  end

  assign o_sck_rise  =  sck_q[SYNC_STAGES-1] & ~sck_prev_q;
  assign o_sck_fall  = ~sck_q[SYNC_STAGES-1] &  sck_prev_q;
  assign o_ncs_rise  =  ncs_q[SYNC_STAGES-1] & ~ncs_prev_q;
  assign o_ncs_fall  = ~ncs_q[SYNC_STAGES-1] &  ncs_prev_q;
  assign o_ncs_sync  =  ncs_q[SYNC_STAGES-1];
  assign o_mosi_sync =  mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_cmd_decoder.sv
// SPI slave that decodes a two-byte {opcode, data} frame into register
// read/write strobes for up to four control modules.
module spi_cmd_decoder
  import spi_cmd_decoder_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_sys_clk,
  input  logic                  i_rst,
  input  logic                  i_sck,
  input  logic                  i_ncs,
  input  logic                  i_mosi,
  output logic                  o_miso,
  output logic                  o_miso_oe,
  output logic [IOC_W-1:0]      o_ioc,
  output logic [7:0]            o_data_in,
  output logic [NUM_MODS-1:0]   o_cs,
  output logic                  o_fetch_cmd,
  output logic                  o_load_cmd,
  input  logic [8*NUM_MODS-1:0] i_mod_data,
  output logic                  o_frame_err
);

  logic sck_rise, sck_fall, ncs_rise, ncs_fall, ncs_sync, mosi_sync;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_sys_clk   (i_sys_clk),
    .i_rst       (i_rst),
    .i_sck       (i_sck),
    .i_ncs       (i_ncs),
    .i_mosi      (i_mosi),
    .o_sck_rise  (sck_rise),
    .o_sck_fall  (sck_fall),
    .o_ncs_rise  (ncs_rise),
    .o_ncs_fall  (ncs_fall),
    .o_ncs_sync  (ncs_sync),
    .o_mosi_sync (mosi_sync)
  );

  state_t               state_q;
  logic [2:0]           cnt_q;
  logic                 rw_q;
  logic [MOD_W-1:0]     mod_q;
  logic [IOC_W-1:0]     ioc_q;
  logic [NUM_MODS-1:0]  cs_q;
  logic [7:0]           data_in_q;
  logic                 fetch_q, load_q, err_q, miso_q;
  logic [6:0]           rx_q;
  logic [7:0]           tx_q;
  logic [7:0]           rx_byte_d;
  logic [7:0]           mod_byte_d;

  assign rx_byte_d  = {rx_q, mosi_sync};
  assign mod_byte_d = i_mod_data[{mod_q, 3'b000} +: 8];

  // Shift registers carry no control meaning, so they are left unreset.
  always_ff @(posedge i_sys_clk) begin
    if (sck_rise) rx_q <= rx_byte_d[6:0];
    if (state_q == ST_CAPTURE)
      tx_q <= {mod_byte_d[6:0], 1'b0};
    else if (state_q == ST_DATA && sck_fall && rw_q && cnt_q != 3'd0)
      tx_q <= {tx_q[6:0], 1'b0};
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      mod_q     <= '0;
      ioc_q     <= '0;
      cs_q      <= '0;
      data_in_q <= '0;
      fetch_q   <= 1'b0;
      load_q    <= 1'b0;
      err_q     <= 1'b0;
      miso_q    <= 1'b0;
    end else begin
      fetch_q <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          miso_q <= 1'b0;
          cnt_q  <= '0;
          if (ncs_fall) state_q <= ST_OPCODE;
        end
        ST_OPCODE: begin
          if (ncs_rise) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
            cs_q    <= '0;
          end else if (sck_rise) begin
            if (cnt_q == 3'd7) begin
              cnt_q <= '0;
              rw_q  <= rx_byte_d[OP_RW_BIT];
              mod_q <= rx_byte_d[OP_MOD_HI:OP_MOD_LO];
              ioc_q <= rx_byte_d[OP_IOC_HI:OP_IOC_LO];
              cs_q  <= mod_onehot(rx_byte_d[OP_MOD_HI:OP_MOD_LO]);
              if (rx_byte_d[OP_RW_BIT]) begin
                state_q <= ST_FETCH;
                fetch_q <= 1'b1;
              end else begin
                state_q <= ST_DATA;
              end
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        ST_FETCH: begin
          if (ncs_rise) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
            cs_q    <= '0;
          end else begin
            state_q <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (ncs_rise) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
            cs_q    <= '0;
          end else begin
            state_q <= ST_DATA;
            miso_q  <= mod_byte_d[7];
          end
        end
        ST_DATA: begin
          if (ncs_rise) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
            cs_q    <= '0;
            miso_q  <= 1'b0;
          end else begin
            // The trailing fall of the opcode byte arrives with cnt_q still 0;
            // skipping it keeps the MSB on the line for the first read sample.
            if (sck_fall && rw_q && cnt_q != 3'd0) miso_q <= tx_q[7];
            if (sck_rise) begin
              if (cnt_q == 3'd7) begin
                cnt_q  <= '0;
                miso_q <= 1'b0;
                if (rw_q) begin
                  state_q <= ST_HOLD;
                end else begin
                  data_in_q <= rx_byte_d;
                  load_q    <= 1'b1;
                  state_q   <= ST_LOAD;
                end
              end else begin
                cnt_q <= cnt_q + 3'd1;
              end
            end
          end
        end
        ST_LOAD: state_q <= ST_HOLD;
        ST_HOLD: begin
          miso_q <= 1'b0;
          if (ncs_sync) begin
            state_q <= ST_IDLE;
            cs_q    <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_miso      = miso_q;
  assign o_miso_oe   = ~ncs_sync;
  assign o_ioc       = ioc_q;
  assign o_data_in   = data_in_q;
  assign o_cs        = cs_q;
  assign o_fetch_cmd = fetch_q;
  assign o_load_cmd  = load_q;
  assign o_frame_err = err_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Bench for spi_cmd_decoder: directed frame table, reset/back-to-back
// sequences and random frames checked against a frame-level model.
module tb_spi_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        ncs = 1'b1;
  logic        mosi = 1'b0;
  logic [31:0] mod_data = '0;
  logic        miso, miso_oe, fetch_cmd, load_cmd, frame_err;
  logic [4:0]  ioc;
  logic [7:0]  data_in;
  logic [3:0]  cs;

  always #5 clk = ~clk;

  spi_cmd_decoder #(.SYNC_STAGES(2)) dut (
    .i_sys_clk   (clk),
    .i_rst       (rst),
    .i_sck       (sck),
    .i_ncs       (ncs),
    .i_mosi      (mosi),
    .o_miso      (miso),
    .o_miso_oe   (miso_oe),
    .o_ioc       (ioc),
    .o_data_in   (data_in),
    .o_cs        (cs),
    .o_fetch_cmd (fetch_cmd),
    .o_load_cmd  (load_cmd),
    .i_mod_data  (mod_data),
    .o_frame_err (frame_err)
  );

  int checks = 0;
  int failures = 0;
  int fetch_tot = 0, load_tot = 0, err_tot = 0, both_tot = 0;

  always @(negedge clk) begin
    if (fetch_cmd) fetch_tot++;
    if (load_cmd) load_tot++;
    if (frame_err) err_tot++;
    if (fetch_cmd && load_cmd) both_tot++;
  end

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  data;
    logic [31:0] md;
    int          nbits;
    logic [3:0]  cs;
    logic [4:0]  ioc;
    logic [7:0]  din;
    int          nfetch;
    int          nload;
    int          nerr;
    logic [7:0]  miso2;
  } vec_t;

  vec_t        tbl[6];
  logic [4:0]  m_ioc;
  logic [7:0]  m_din;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0 master, SCK = sys_clk/16; MISO sampled at each rising SCK.
  task automatic spi_bits(input logic [23:0] tx, input int nbits, output logic [23:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[23-i];
      wait_cyc(8);
      rx[23-i] = miso;
      sck = 1'b1;
      wait_cyc(8);
      sck = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [23:0] tx, input int nbits, input int gap,
                           output logic [23:0] rx, output logic [3:0] cs_pre,
                           output logic oe_pre);
    ncs = 1'b0;
    spi_bits(tx, nbits, rx);
    wait_cyc(8);
    cs_pre = cs;
    oe_pre = miso_oe;
    ncs  = 1'b1;
    mosi = 1'b0;
    wait_cyc(gap);
  endtask

  task automatic apply_and_check(input string tag, input vec_t v, input int gap);
    logic [23:0] rx, mask;
    logic [3:0]  cs_pre;
    logic        oe_pre;
    int f0, l0, e0, b0;
    mod_data = v.md;
    f0 = fetch_tot; l0 = load_tot; e0 = err_tot; b0 = both_tot;
    spi_frame({v.op, v.data, 8'h00}, v.nbits, gap, rx, cs_pre, oe_pre);
    mask = (v.nbits >= 24) ? 24'hFFFFFF : ~(24'hFFFFFF >> v.nbits);
    check({tag, "_cs"}, cs_pre, v.cs);
    check({tag, "_oe_in"}, oe_pre, 1);
    check({tag, "_oe_out"}, miso_oe, 0);
    check({tag, "_cs_clr"}, cs, 0);
    check({tag, "_ioc"}, ioc, v.ioc);
    check({tag, "_din"}, data_in, v.din);
    check({tag, "_fetch"}, fetch_tot - f0, v.nfetch);
    check({tag, "_load"}, load_tot - l0, v.nload);
    check({tag, "_err"}, err_tot - e0, v.nerr);
    check({tag, "_both"}, both_tot - b0, 0);
    check({tag, "_miso"}, rx, {8'h00, v.miso2, 8'h00} & mask);
  endtask

  function automatic vec_t model(input logic [7:0] op, input logic [7:0] data,
                                 input logic [31:0] md, input int nbits);
    vec_t v;
    bit   rw, opc_done, full;
    int   mod;
    rw       = op[7];
    mod      = int'(op[6:5]);
    opc_done = (nbits >= 8);
    full     = (nbits >= 16);
    v.op = op; v.data = data; v.md = md; v.nbits = nbits;
    v.cs     = opc_done ? (4'b0001 << mod) : 4'b0000;
    v.ioc    = opc_done ? op[4:0] : m_ioc;
    v.nfetch = (opc_done && rw) ? 1 : 0;
    v.nload  = (full && !rw) ? 1 : 0;
    v.din    = (v.nload == 1) ? data : m_din;
    v.nerr   = full ? 0 : 1;
    v.miso2  = rw ? 8'((md >> (8 * mod)) & 32'hFF) : 8'h00;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    ncs = 1'b1;
    sck = 1'b0;
    mosi = 1'b0;
    wait_cyc(6);
    rst = 1'b0;
    wait_cyc(4);
  endtask

  initial begin
    logic [23:0] rx;
    int f0, l0, e0;
    vec_t v;
    int nb_opts[6];

    tbl[0] = '{op:8'h05, data:8'h0F, md:32'h0000_0000, nbits:16, cs:4'b0001, ioc:5'h05, din:8'h0F, nfetch:0, nload:1, nerr:0, miso2:8'h00};
    tbl[1] = '{op:8'hA6, data:8'h00, md:32'h4433_0311, nbits:16, cs:4'b0010, ioc:5'h06, din:8'h0F, nfetch:1, nload:0, nerr:0, miso2:8'h03};
    tbl[2] = '{op:8'h60, data:8'hA5, md:32'h0000_0000, nbits:12, cs:4'b1000, ioc:5'h00, din:8'h0F, nfetch:0, nload:0, nerr:1, miso2:8'h00};
    tbl[3] = '{op:8'h80, data:8'h00, md:32'h1122_3344, nbits:24, cs:4'b0001, ioc:5'h00, din:8'h0F, nfetch:1, nload:0, nerr:0, miso2:8'h44};
    tbl[4] = '{op:8'h7F, data:8'hFF, md:32'h0000_0000, nbits:16, cs:4'b1000, ioc:5'h1F, din:8'hFF, nfetch:0, nload:1, nerr:0, miso2:8'h00};
    tbl[5] = '{op:8'hDD, data:8'h00, md:32'hAA96_0000, nbits:16, cs:4'b0100, ioc:5'h1D, din:8'hFF, nfetch:1, nload:0, nerr:0, miso2:8'h96};

    // Outputs while reset is held.
    rst = 1'b1;
    wait_cyc(4);
    check("rst_outputs", {miso, miso_oe, fetch_cmd, load_cmd, frame_err, cs}, 0);
    check("rst_ioc", ioc, 0);
    check("rst_din", data_in, 0);
    rst = 1'b0;
    wait_cyc(4);

    for (int i = 0; i < 6; i++) begin
      apply_and_check($sformatf("tbl%0d", i), tbl[i], 10);
    end

    // Reset during the data byte of a write, then a fresh write.
    do_reset();
    f0 = fetch_tot; l0 = load_tot; e0 = err_tot;
    mod_data = '0;
    ncs = 1'b0;
    spi_bits({8'h22, 8'hC3, 8'h00}, 12, rx);
    rst = 1'b1;
    wait_cyc(1);
    ncs = 1'b1;
    mosi = 1'b0;
    wait_cyc(6);
    check("midrst_cs", cs, 0);
    check("midrst_din", data_in, 0);
    rst = 1'b0;
    wait_cyc(6);
    check("midrst_load", load_tot - l0, 0);
    check("midrst_err", err_tot - e0, 0);
    check("midrst_fetch", fetch_tot - f0, 0);
    v = '{op:8'h01, data:8'h01, md:32'h0, nbits:16, cs:4'b0001, ioc:5'h01, din:8'h01, nfetch:0, nload:1, nerr:0, miso2:8'h00};
    apply_and_check("after_rst", v, 10);

    // Back-to-back frames with the minimum nCS-high gap.
    v = '{op:8'h25, data:8'h5A, md:32'h0, nbits:16, cs:4'b0010, ioc:5'h05, din:8'h5A, nfetch:0, nload:1, nerr:0, miso2:8'h00};
    apply_and_check("b2b_a", v, 4);
    v = '{op:8'hC3, data:8'h00, md:32'h00E7_0000, nbits:16, cs:4'b0100, ioc:5'h03, din:8'h5A, nfetch:1, nload:0, nerr:0, miso2:8'hE7};
    apply_and_check("b2b_b", v, 4);

    // Random frames, including aborts and over-long frames.
    nb_opts = '{16, 16, 24, 12, 5, 8};
    do_reset();
    m_ioc = '0;
    m_din = '0;
    for (int i = 0; i < 30; i++) begin
      v = model(8'($urandom), 8'($urandom), $urandom,
                nb_opts[$urandom_range(0, 5)]);
      apply_and_check($sformatf("rnd%0d", i), v, $urandom_range(4, 20));
      m_ioc = v.ioc;
      m_din = v.din;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
